// File: rtl/serial_mod_checker.sv
// Streaming remainder engine: folds a W-bit-per-beat number into r = value mod MOD,
// with valid/ready input framing and a held, back-pressured per-frame result.
//
// state  | meaning
// S_IDLE | no frame open; next accepted beat starts from r=0, wt=1
// S_RUN  | frame open; r/wt carry the running remainder and digit weight
module serial_mod_checker #(
    parameter int MOD       = 3,
    parameter int W         = 1,
    parameter bit LSB_FIRST = 1'b0,
    localparam int RW       = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          div_now,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_rem,
    output logic          out_divisible
);

    localparam int MW = RW + W;
    localparam int LW = RW + W + RW;
    localparam logic [MW-1:0] MOD_M = MW'(MOD);
    localparam logic [LW-1:0] MOD_L = LW'(MOD);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [RW-1:0] wt_q, wt_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_rem_q, out_rem_d;
    logic          out_div_q, out_div_d;

    logic [RW-1:0] rc, wc;
    logic [RW-1:0] r_n, wt_n;
    logic [MW-1:0] msb_acc;
    logic [LW-1:0] lsb_acc;
    logic          fire;

    assign in_ready      = !out_valid_q || out_ready;
    assign fire          = in_valid && in_ready;
    assign div_now       = fire && (r_n == '0);
    assign out_valid     = out_valid_q;
    assign out_rem       = out_rem_q;
    assign out_divisible = out_div_q;

    // Idle forces the fresh-frame operands so a finished frame's leftovers never leak in.
    always_comb begin
        rc      = (state_q == S_IDLE) ? '0 : r_q;
        wc      = (state_q == S_IDLE) ? RW'(1) : wt_q;
        msb_acc = {rc, in_data};
        lsb_acc = LW'(in_data) * LW'(wc) + LW'(rc);
        wt_n    = RW'({wc, {W{1'b0}}} % MOD_M);
        if (LSB_FIRST) begin
            r_n = RW'(lsb_acc % MOD_L);
        end else begin
            r_n = RW'(msb_acc % MOD_M);
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        wt_d        = wt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_rem_d   = out_rem_q;
        out_div_d   = out_div_q;
        if (fire) begin
            r_d  = r_n;
            wt_d = wt_n;
            if (in_last) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                out_rem_d   = r_n;
                out_div_d   = (r_n == '0);
            end else begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            wt_q        <= RW'(1);
            out_valid_q <= 1'b0;
            out_rem_q   <= '0;
            out_div_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            wt_q        <= wt_d;
            out_valid_q <= out_valid_d;
            out_rem_q   <= out_rem_d;
            out_div_q   <= out_div_d;
        end
    end

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: three configurations (mod-3 MSB, mod-3 LSB, mod-5 nibble)
// checked against a digit-list reference model plus hand-computed vector tables.
module tb_serial_mod_checker;

    localparam int MOD_K [3] = '{3, 3, 5};
    localparam int W_K   [3] = '{1, 1, 4};
    localparam int LSB_K [3] = '{0, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      v, l, ordy;
    logic [2:0][3:0] d;
    logic [2:0]      iry, dn, ov, dvs;
    logic [1:0]      rem0, rem1;
    logic [2:0]      rem2;

    serial_mod_checker #(.MOD(3), .W(1), .LSB_FIRST(1'b0)) u_m3 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(iry[0]), .in_data(d[0][0:0]),
        .in_last(l[0]), .div_now(dn[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_rem(rem0), .out_divisible(dvs[0]));

    serial_mod_checker #(.MOD(3), .W(1), .LSB_FIRST(1'b1)) u_l3 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(iry[1]), .in_data(d[1][0:0]),
        .in_last(l[1]), .div_now(dn[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_rem(rem1), .out_divisible(dvs[1]));

    serial_mod_checker #(.MOD(5), .W(4), .LSB_FIRST(1'b0)) u_m5 (
        .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(iry[2]), .in_data(d[2]),
        .in_last(l[2]), .div_now(dn[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_rem(rem2), .out_divisible(dvs[2]));

    int checks = 0;
    int errors = 0;

    // Reference model: the open frame is kept as its list of digits in arrival order.
    int dig [3][256];
    int len [3];
    int m_ov [3];
    int m_rem [3];
    int m_dv [3];
    int s_dn [3];

    typedef struct {
        int dut; int v; int d; int l; int ordy;
        int e_dn; int e_ov; int e_rem; int e_dv;
    } vec_t;
    vec_t tbl[$];

    function automatic int dut_rem(int k);
        if (k == 0) return int'(rem0);
        if (k == 1) return int'(rem1);
        return int'(rem2);
    endfunction

    // Value of the open frame extended by one more digit, reduced mod MOD, via Horner
    // from the most significant digit, whichever end of the frame that is.
    function automatic int ref_rem(int k, int extra);
        int acc;
        int base;
        base = 1 << W_K[k];
        acc  = 0;
        if (LSB_K[k] == 0) begin
            for (int i = 0; i < len[k]; i++) acc = (acc * base + dig[k][i]) % MOD_K[k];
            acc = (acc * base + extra) % MOD_K[k];
        end else begin
            acc = extra % MOD_K[k];
            for (int i = len[k] - 1; i >= 0; i--) acc = (acc * base + dig[k][i]) % MOD_K[k];
        end
        return acc;
    endfunction

    task automatic chk(string name, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d want %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic tick();
        int fire [3];
        int rn   [3];
        int rdy;
        int dm;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rdy     = (m_ov[k] == 0 || ordy[k]) ? 1 : 0;
            fire[k] = (v[k] && rdy != 0) ? 1 : 0;
            dm      = int'(d[k]) & ((1 << W_K[k]) - 1);
            rn[k]   = (fire[k] != 0) ? ref_rem(k, dm) : 1;
            s_dn[k] = int'(dn[k]);
            chk("in_ready", k, int'(iry[k]), rdy);
            chk("div_now", k, int'(dn[k]), (fire[k] != 0 && rn[k] == 0) ? 1 : 0);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            dm = int'(d[k]) & ((1 << W_K[k]) - 1);
            if (rst) begin
                len[k] = 0; m_ov[k] = 0; m_rem[k] = 0; m_dv[k] = 0;
            end else begin
                if (m_ov[k] != 0 && ordy[k]) m_ov[k] = 0;
                if (fire[k] != 0) begin
                    if (l[k]) begin
                        m_ov[k] = 1; m_rem[k] = rn[k]; m_dv[k] = (rn[k] == 0) ? 1 : 0;
                        len[k]  = 0;
                    end else begin
                        dig[k][len[k]] = dm;
                        len[k]++;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("out_valid", k, int'(ov[k]), m_ov[k]);
            chk("out_rem", k, dut_rem(k), m_rem[k]);
            chk("out_divisible", k, int'(dvs[k]), m_dv[k]);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; v = '0; l = '0; ordy = '1; d = '0;
    endtask

    task automatic beat(int k, int vv, int dd, int ll, int rr);
        idle_inputs();
        v[k] = vv[0]; d[k] = dd[3:0]; l[k] = ll[0]; ordy[k] = rr[0];
        tick();
    endtask

    initial begin
        // Test 1: 1,1,0 = 6 (running 1,3,6 -> div_now 0,1,1)
        tbl.push_back('{0,1,1,0,1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,1, 1,0,0,0});
        tbl.push_back('{0,1,0,1,1, 1,1,0,1});
        // Test 2: 1,0,1 = 5
        tbl.push_back('{0,1,1,0,1, 0,0,0,1});
        tbl.push_back('{0,1,0,0,1, 0,0,0,1});
        tbl.push_back('{0,1,1,1,1, 0,1,2,0});
        tbl.push_back('{0,0,0,0,1, 0,0,2,0});
        // Test 3: LSB-first 0,1,1 = 6 then 1,0,1 = 5
        tbl.push_back('{1,1,0,0,1, 1,0,0,0});
        tbl.push_back('{1,1,1,0,1, 0,0,0,0});
        tbl.push_back('{1,1,1,1,1, 1,1,0,1});
        tbl.push_back('{1,1,1,0,1, 0,0,0,1});
        tbl.push_back('{1,1,0,0,1, 0,0,0,1});
        tbl.push_back('{1,1,1,1,1, 0,1,2,0});
        // Test 4: mod 5 nibbles 0x1,0x7 = 23 then single beat 0xA replacing with no bubble
        tbl.push_back('{2,1,1,0,1, 0,0,0,0});
        tbl.push_back('{2,1,7,1,1, 0,1,3,0});
        tbl.push_back('{2,1,10,1,1, 1,1,0,1});
        // Test 5: frame 6 published under backpressure, held 5 cycles with a last beat offered
        tbl.push_back('{0,1,1,0,0, 0,0,2,0});
        tbl.push_back('{0,1,1,0,0, 1,0,2,0});
        tbl.push_back('{0,1,0,1,0, 1,1,0,1});
        for (int i = 0; i < 5; i++) tbl.push_back('{0,1,1,1,0, 0,1,0,1});
        tbl.push_back('{0,1,1,1,1, 0,1,1,0});
        tbl.push_back('{0,1,1,0,1, 0,0,1,0});
        tbl.push_back('{0,1,0,0,1, 0,0,1,0});
        tbl.push_back('{0,1,1,1,1, 0,1,2,0});
        tbl.push_back('{0,0,0,0,1, 0,0,2,0});

        for (int k = 0; k < 3; k++) begin
            len[k] = 0; m_ov[k] = 0; m_rem[k] = 0; m_dv[k] = 0;
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_out_valid", k, int'(ov[k]), 0);
            chk("reset_out_rem", k, dut_rem(k), 0);
            chk("reset_out_divisible", k, int'(dvs[k]), 0);
            chk("reset_in_ready", k, int'(iry[k]), 1);
        end

        foreach (tbl[i]) begin
            beat(tbl[i].dut, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
            chk("tbl_div_now", tbl[i].dut, s_dn[tbl[i].dut], tbl[i].e_dn);
            chk("tbl_out_valid", tbl[i].dut, int'(ov[tbl[i].dut]), tbl[i].e_ov);
            chk("tbl_out_rem", tbl[i].dut, dut_rem(tbl[i].dut), tbl[i].e_rem);
            chk("tbl_out_divisible", tbl[i].dut, int'(dvs[tbl[i].dut]), tbl[i].e_dv);
        end

        // Test 6: partial frame 1,0 discarded by reset; 1,1,0 must then give 0, not a stale value
        beat(0, 1, 1, 0, 1);
        beat(0, 1, 0, 0, 1);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_out_valid", 0, int'(ov[0]), 0);
        chk("rst_mid_out_rem", 0, dut_rem(0), 0);
        beat(0, 1, 1, 0, 1);
        beat(0, 1, 1, 0, 1);
        beat(0, 1, 0, 1, 1);
        chk("rst_mid_result_valid", 0, int'(ov[0]), 1);
        chk("rst_mid_result_rem", 0, dut_rem(0), 0);
        chk("rst_mid_result_div", 0, int'(dvs[0]), 1);

        // Random traffic with backpressure and occasional reset, checked by the model
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < 3; k++) begin
                v[k]    = ($urandom_range(0, 3) != 0);
                d[k]    = 4'($urandom);
                l[k]    = (len[k] >= 200) || ($urandom_range(0, 5) == 0);
                ordy[k] = ($urandom_range(0, 9) < 7);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
